// File: rtl/fp8_divider.sv
// Sequential FP8 (1/4/3, bias 7) divider with a restoring mantissa core and start/done handshake.
// Define FP8_DIV_RNE_EN to round the quotient to nearest-even instead of truncating it.
module fp8_divider #(
    parameter int EXP_BIAS = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_div,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       busy,
    output logic       done_div,
    output logic [7:0] quotient,
    output logic       div_by_zero,
    output logic       invalid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DIV,
        S_NORM,
        S_DONE
    } state_t;

    localparam logic signed [6:0] BIAS7 = 7'(EXP_BIAS);

    state_t            state_q, state_d;
    logic [7:0]        a_q, a_d, b_q, b_d;
    logic [9:0]        rem_q, rem_d;
    logic [3:0]        div_q, div_d;
    logic [5:0]        q_q, q_d;
    logic [2:0]        cnt_q, cnt_d;
    logic signed [6:0] exp_q, exp_d;
    logic [7:0]        res_q, res_d;
    logic              res_dbz_q, res_dbz_d, res_inv_q, res_inv_d;
    logic              busy_q, busy_d, done_div_q, done_div_d;
    logic [7:0]        quotient_q, quotient_d;
    logic              div_by_zero_q, div_by_zero_d, invalid_q, invalid_d;

    logic              a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, res_sign;
    logic [9:0]        trial;
    logic              fits;
    logic signed [6:0] e_norm, e_fin;
    logic [2:0]        mant_norm, mant_fin;
    logic [7:0]        norm_res;

    assign a_nan    = (a_q[6:3] == 4'hF) && (a_q[2:0] != 3'b000);
    assign a_inf    = (a_q[6:3] == 4'hF) && (a_q[2:0] == 3'b000);
    assign a_zero   = (a_q[6:3] == 4'h0);
    assign b_nan    = (b_q[6:3] == 4'hF) && (b_q[2:0] != 3'b000);
    assign b_inf    = (b_q[6:3] == 4'hF) && (b_q[2:0] == 3'b000);
    assign b_zero   = (b_q[6:3] == 4'h0);
    assign res_sign = a_q[7] ^ b_q[7];

    // The divisor is aligned to the current quotient bit weight, so the quotient can never exceed 6 bits.
    assign trial = {6'b000000, div_q} << cnt_q;
    assign fits  = (rem_q >= trial);

`ifdef FP8_DIV_RNE_EN
    logic       guard, sticky;
    logic [3:0] mant_rnd;
`endif

    // Normalise the 6-bit quotient, optionally round, then apply the overflow and flush limits.
    always_comb begin
        e_norm    = q_q[5] ? exp_q : exp_q - 7'sd1;
        mant_norm = q_q[5] ? q_q[4:2] : q_q[3:1];
`ifdef FP8_DIV_RNE_EN
        guard    = q_q[5] ? q_q[1] : q_q[0];
        sticky   = q_q[5] ? (q_q[0] | (rem_q != 10'd0)) : (rem_q != 10'd0);
        mant_rnd = {1'b0, mant_norm} + {3'b000, guard & (sticky | mant_norm[0])};
        if (mant_rnd[3]) begin
            mant_fin = 3'b000;
            e_fin    = e_norm + 7'sd1;
        end else begin
            mant_fin = mant_rnd[2:0];
            e_fin    = e_norm;
        end
`else
        mant_fin = mant_norm;
        e_fin    = e_norm;
`endif
        if (e_fin >= 7'sd15) begin
            norm_res = {res_sign, 7'b1111000};
        end else if (e_fin <= 7'sd0) begin
            norm_res = {res_sign, 7'b0000000};
        end else begin
            norm_res = {res_sign, e_fin[3:0], mant_fin};
        end
    end

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        rem_d         = rem_q;
        div_d         = div_q;
        q_d           = q_q;
        cnt_d         = cnt_q;
        exp_d         = exp_q;
        res_d         = res_q;
        res_dbz_d     = res_dbz_q;
        res_inv_d     = res_inv_q;
        quotient_d    = quotient_q;
        div_by_zero_d = div_by_zero_q;
        invalid_d     = invalid_q;
        done_div_d    = 1'b0;
        busy_d        = (state_q != S_IDLE) && (state_q != S_DONE);

        case (state_q)
            S_IDLE: begin
                if (start_div) begin
                    a_d           = a;
                    b_d           = b;
                    div_by_zero_d = 1'b0;
                    invalid_d     = 1'b0;
                    state_d       = S_CHECK;
                end
            end
            S_CHECK: begin
                res_dbz_d = 1'b0;
                res_inv_d = 1'b0;
                state_d   = S_DONE;
                if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
                    res_d     = 8'h7F;
                    res_inv_d = 1'b1;
                end else if (a_inf) begin
                    res_d = {res_sign, 7'b1111000};
                end else if (b_zero) begin
                    res_d     = {res_sign, 7'b1111000};
                    res_dbz_d = 1'b1;
                end else if (a_zero || b_inf) begin
                    res_d = {res_sign, 7'b0000000};
                end else begin
                    rem_d   = {1'b0, 1'b1, a_q[2:0], 5'b00000};
                    div_d   = {1'b1, b_q[2:0]};
                    q_d     = 6'd0;
                    cnt_d   = 3'd5;
                    exp_d   = $signed({3'b000, a_q[6:3]}) - $signed({3'b000, b_q[6:3]}) + BIAS7;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                if (fits) begin
                    rem_d = rem_q - trial;
                end
                q_d = {q_q[4:0], fits};
                if (cnt_q == 3'd0) begin
                    state_d = S_NORM;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_NORM: begin
                res_d   = norm_res;
                state_d = S_DONE;
            end
            S_DONE: begin
                quotient_d    = res_q;
                div_by_zero_d = res_dbz_q;
                invalid_d     = res_inv_q;
                done_div_d    = 1'b1;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            a_q           <= 8'h00;
            b_q           <= 8'h00;
            rem_q         <= 10'd0;
            div_q         <= 4'd0;
            q_q           <= 6'd0;
            cnt_q         <= 3'd0;
            exp_q         <= 7'sd0;
            res_q         <= 8'h00;
            res_dbz_q     <= 1'b0;
            res_inv_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_div_q    <= 1'b0;
            quotient_q    <= 8'h00;
            div_by_zero_q <= 1'b0;
            invalid_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            rem_q         <= rem_d;
            div_q         <= div_d;
            q_q           <= q_d;
            cnt_q         <= cnt_d;
            exp_q         <= exp_d;
            res_q         <= res_d;
            res_dbz_q     <= res_dbz_d;
            res_inv_q     <= res_inv_d;
            busy_q        <= busy_d;
            done_div_q    <= done_div_d;
            quotient_q    <= quotient_d;
            div_by_zero_q <= div_by_zero_d;
            invalid_q     <= invalid_d;
        end
    end

    assign busy        = busy_q;
    assign done_div    = done_div_q;
    assign quotient    = quotient_q;
    assign div_by_zero = div_by_zero_q;
    assign invalid     = invalid_q;

endmodule

// File: tb/tb_fp8_divider.sv
// Scoreboard bench for fp8_divider: a real-valued reference model predicts each result and its latency.
module tb_fp8_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_div = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       busy, done_div, div_by_zero, invalid;
    logic [7:0] quotient;

    fp8_divider #(.EXP_BIAS(7)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_div(start_div),
        .a(a),
        .b(b),
        .busy(busy),
        .done_div(done_div),
        .quotient(quotient),
        .div_by_zero(div_by_zero),
        .invalid(invalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic       dbz;
        logic       inv;
        int         edge0;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    int         done_seen = 0;
    logic [7:0] last_q = 8'h00;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // Reference: specials from the encoding rules, everything else from the real-valued quotient.
    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
        exp_t r;
        int   xe, ye, xm, ym, e, m, ef;
        logic s, xnan, xinf, xzero, ynan, yinf, yzero;
        real  v, mr, frac;
        xe = int'(x[6:3]); ye = int'(y[6:3]);
        xm = int'(x[2:0]); ym = int'(y[2:0]);
        s = x[7] ^ y[7];
        xnan = (xe == 15) && (xm != 0); xinf = (xe == 15) && (xm == 0); xzero = (xe == 0);
        ynan = (ye == 15) && (ym != 0); yinf = (ye == 15) && (ym == 0); yzero = (ye == 0);
        r.dbz = 1'b0; r.inv = 1'b0; r.lat = 2; r.edge0 = 0;
        if (xnan || ynan || (xinf && yinf) || (xzero && yzero)) begin
            r.q = 8'h7F; r.inv = 1'b1;
        end else if (xinf) begin
            r.q = {s, 7'b1111000};
        end else if (yzero) begin
            r.q = {s, 7'b1111000}; r.dbz = 1'b1;
        end else if (xzero || yinf) begin
            r.q = {s, 7'b0000000};
        end else begin
            r.lat = 9;
            v = real'(8 + xm) / real'(8 + ym);
            e = xe - ye;
            while (v >= 2.0) begin v = v / 2.0; e++; end
            while (v < 1.0) begin v = v * 2.0; e--; end
            mr = (v - 1.0) * 8.0;
            m = int'($floor(mr));
            frac = mr - real'(m);
`ifdef FP8_DIV_RNE_EN
            if (frac > 0.5 || (frac == 0.5 && (m % 2) == 1)) m++;
            if (m == 8) begin m = 0; e++; end
`else
            if (frac < 0.0) m = 0;
`endif
            ef = e + 7;
            if (ef >= 15) r.q = {s, 7'b1111000};
            else if (ef <= 0) r.q = {s, 7'b0000000};
            else r.q = {s, ef[3:0], m[2:0]};
        end
        return r;
    endfunction

    // Monitor: pops the scoreboard on every done_div and checks in-flight behaviour between.
    always @(negedge clk) begin
        exp_t e;
        int   rel;
        if (!rst_n) last_q = 8'h00;
        if (done_div) begin
            done_seen++;
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("[TB] FAIL unexpected_done: got done_div=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                checkOutput("latency", cyc, e.edge0 + e.lat);
                checkOutput("quotient", {24'd0, quotient}, {24'd0, e.q});
                checkOutput("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                checkOutput("invalid", {31'd0, invalid}, {31'd0, e.inv});
                checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
                last_q = e.q;
            end
        end else if (sb.size() > 0 && cyc >= sb[0].edge0) begin
            rel = cyc - sb[0].edge0;
            checkOutput("busy", {31'd0, busy}, (rel >= 1) ? 32'd1 : 32'd0);
            checkOutput("flags_cleared", {30'd0, div_by_zero, invalid}, 32'd0);
            checkOutput("quotient_held", {24'd0, quotient}, {24'd0, last_q});
        end
    end

    // Issues one operation; optional start pulse while busy and optional reset at a relative edge.
    task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y,
                                 input int pulse_at, input int reset_at);
        exp_t e;
        int   d0;
        bit   got;
        a = x; b = y; start_div = 1'b1;
        e = model(x, y);
        e.edge0 = cyc + 1;
        sb.push_back(e);
        d0 = done_seen;
        got = 1'b0;
        @(negedge clk); #1;
        start_div = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        for (int k = 1; k <= 20; k++) begin
            start_div = (k == pulse_at);
            if (k == pulse_at) begin a = 8'($urandom); b = 8'($urandom); end
            if (k == reset_at) begin
                rst_n = 1'b0;
                sb.delete();
            end
            @(negedge clk); #1;
            start_div = 1'b0;
            if (k == reset_at) begin
                rst_n = 1'b1;
                checkOutput("reset_outputs", {20'd0, busy, done_div, quotient, div_by_zero, invalid}, 32'd0);
            end
            if (reset_at == 0 && done_seen != d0) begin
                got = 1'b1;
                break;
            end
        end
        if (reset_at == 0 && !got) begin
            tests++; fails++;
            $display("[TB] FAIL timeout: got no done_div expected one for %0h/%0h", x, y);
            sb.delete();
        end
        if (pulse_at != 0) begin
            repeat (12) @(negedge clk);
            #1;
        end
    endtask

    logic [7:0] dir_a[10] = '{8'h40, 8'h38, 8'hC0, 8'h40, 8'h00, 8'h78, 8'h40, 8'h77, 8'h08, 8'h79};
    logic [7:0] dir_b[10] = '{8'h38, 8'h3C, 8'h38, 8'h00, 8'h00, 8'h78, 8'h78, 8'h08, 8'h77, 8'h38};

    initial begin
        logic [7:0] x, y;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_state", {20'd0, busy, done_div, quotient, div_by_zero, invalid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;

        for (int i = 0; i < 10; i++) applyStimulus(dir_a[i], dir_b[i], 0, 0);

        applyStimulus(8'h40, 8'h38, 3, 0);
        applyStimulus(8'h40, 8'h38, 0, 5);
        applyStimulus(8'h38, 8'h3C, 0, 0);

        for (int i = 0; i < 160; i++) begin
            if (i % 2 == 0) begin
                x = {1'($urandom), 4'($urandom_range(14, 1)), 3'($urandom)};
                y = {1'($urandom), 4'($urandom_range(14, 1)), 3'($urandom)};
            end else begin
                x = 8'($urandom);
                y = 8'($urandom);
            end
            applyStimulus(x, y, 0, 0);
        end

        repeat (10) @(negedge clk);
        #1;
        checkOutput("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
